// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between the host/FIFO side and uart_tx
interface uart_tx_if;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;

    modport master (
        output valid_i,
        output data_i,
        input  ready_o
    );

    modport slave (
        input  valid_i,
        input  data_i,
        output ready_o
    );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter, one frame in flight, flop-driven line
// Optional even/odd parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BIT_RATE  = 9600,
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic      clk_i,
    input  logic      nreset_i,
    uart_tx_if.slave  bus,
    output logic      tx_o,
    output logic      busy_o
);

    localparam int                CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int                BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST    = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_cnt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift;
    logic              r_tx;
    logic              w_tx;
    logic              w_ready;
    logic              w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
    logic              w_parity;
`endif

    assign w_ready     = nreset_i && (r_state == S_IDLE);
    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign bus.ready_o = w_ready;
    assign tx_o        = r_tx;
    assign busy_o      = (r_state != S_IDLE);

    // The line value is computed for the state being entered, so it is registered on the same edge.
    always_comb begin
        w_state   = r_state;
        w_baud    = r_baud;
        w_bit_cnt = r_bit_cnt;
        w_shift   = r_shift;
        w_tx      = r_tx;
`ifdef UART_TX_PARITY_EN
        w_parity  = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx      = 1'b1;
                w_baud    = '0;
                w_bit_cnt = '0;
                if (bus.valid_i && w_ready) begin
                    w_state = S_START;
                    w_shift = bus.data_i;
                    w_tx    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_parity = (^bus.data_i) ^ PARITY_ODD;
`endif
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_baud  = '0;
                    w_state = S_DATA;
                    w_tx    = r_shift[0];
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt = '0;
`ifdef UART_TX_PARITY_EN
                        w_state = S_PARITY;
                        w_tx    = r_parity;
`else
                        w_state = S_STOP;
                        w_tx    = 1'b1;
`endif
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        w_shift   = {1'b0, r_shift[7:1]};
                        w_tx      = r_shift[1];
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_baud  = '0;
                    w_state = S_STOP;
                    w_tx    = 1'b1;
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
`endif
            S_STOP: begin
                w_tx = 1'b1;
                // Bit counter is reused to count stop bits.
                if (w_bit_end) begin
                    w_baud = '0;
                    if (r_bit_cnt == STOP_LAST) begin
                        w_bit_cnt = '0;
                        w_state   = S_IDLE;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_baud    = '0;
                w_bit_cnt = '0;
                w_tx      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_baud    <= w_baud;
            r_bit_cnt <= w_bit_cnt;
            r_shift   <= w_shift;
            r_tx      <= w_tx;
`ifdef UART_TX_PARITY_EN
            r_parity  <= w_parity;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized frame-level bench for uart_tx (1 and 2 stop bits)
module tb_uart_tx;
    localparam int CLK_HZ   = 16;
    localparam int BIT_RATE = 1;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam bit PODD     = 1'b0;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_data  = 8'h00;
    logic       sel      = 1'b0;

    logic tx1, busy1, tx2, busy2;
    logic cur_tx, cur_ready, cur_busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_if bus1();
    uart_tx_if bus2();

    assign bus1.valid_i = tb_valid & ~sel;
    assign bus1.data_i  = tb_data;
    assign bus2.valid_i = tb_valid & sel;
    assign bus2.data_i  = tb_data;

    assign cur_tx    = sel ? tx2 : tx1;
    assign cur_busy  = sel ? busy2 : busy1;
    assign cur_ready = sel ? bus2.ready_o : bus1.ready_o;

    uart_tx #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(PODD)
`endif
    ) dut1 (
        .clk_i(clk), .nreset_i(rst_n), .bus(bus1), .tx_o(tx1), .busy_o(busy1)
    );

    uart_tx #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .STOP_BITS(2)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(PODD)
`endif
    ) dut2 (
        .clk_i(clk), .nreset_i(rst_n), .bus(bus2), .tx_o(tx2), .busy_o(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_tx", cur_tx, 1);
            check("idle_ready", cur_ready, 1);
            check("idle_busy", cur_busy, 0);
        end
    endtask

    // Expected line: start, data LSB first, optional parity, stop bit(s); each one bit period.
    task automatic run_frame(input logic [7:0] b, input bit hold, input int nstop, input int pulse_at);
        bit         exp_bits[$];
        bit         rx[$];
        int         fl;
        logic [7:0] rx_byte;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        exp_bits.push_back((^b) ^ PODD);
`endif
        for (int s = 0; s < nstop; s++) exp_bits.push_back(1'b1);
        fl = exp_bits.size() * CPB;

        @(negedge clk);
        check("pre_ready", cur_ready, 1);
        check("pre_busy", cur_busy, 0);
        check("pre_tx", cur_tx, 1);
        tb_data  = b;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) tb_valid = 1'b0;
        tb_data = 8'($urandom);

        for (int c = 0; c < fl; c++) begin
            @(negedge clk);
            check("tx_bit", cur_tx, exp_bits[c / CPB]);
            check("busy_ready", cur_ready, 0);
            check("busy_high", cur_busy, 1);
            if (c % CPB == CPB / 2) rx.push_back(cur_tx);
            if (c == pulse_at) begin
                tb_valid = 1'b1;
                tb_data  = 8'h3C;
            end else if (c == pulse_at + 1 && !hold) begin
                tb_valid = 1'b0;
            end else if (c % 7 == 3) begin
                tb_data = 8'($urandom);
            end
        end

        check("rx_start", rx[0], 0);
        for (int i = 0; i < 8; i++) rx_byte[i] = rx[i + 1];
        check("rx_data", rx_byte, b);
`ifdef UART_TX_PARITY_EN
        check("rx_parity", rx[9], (^b) ^ PODD);
`endif
        check("rx_stop", rx[rx.size() - 1], 1);
    endtask

    initial begin
        bit         hold;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_tx1", tx1, 1);
        check("rst_tx2", tx2, 1);
        check("rst_ready1", bus1.ready_o, 0);
        check("rst_busy1", busy1, 0);
        check("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready1", bus1.ready_o, 1);

        run_frame(8'hA5, 1'b0, 1, -1);
        idle(2);
        run_frame(8'h00, 1'b1, 1, -1);
        run_frame(8'hFF, 1'b0, 1, -1);
        idle(1);
        run_frame(8'h81, 1'b0, 1, 5 * CPB + 3);
        idle(2);
        run_frame(8'h01, 1'b0, 1, -1);
        idle(1);

        @(negedge clk);
        tb_data  = 8'h55;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        repeat (71) @(negedge clk);
        check("pre_abort_tx", tx1, 0);
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx1, 1);
        check("abort_ready", bus1.ready_o, 0);
        check("abort_busy", busy1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_rel_ready", bus1.ready_o, 1);
        run_frame(8'h0F, 1'b0, 1, -1);

        for (int i = 0; i < 6; i++) begin
            hold = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            b    = 8'($urandom);
            run_frame(b, hold, 1, (i == 2) ? 40 : -1);
            if (!hold) idle($urandom_range(0, 3));
        end

        idle(1);
        sel = 1'b1;
        run_frame(8'hFF, 1'b0, 2, -1);
        idle(1);
        run_frame(8'h3A, 1'b1, 2, -1);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            run_frame(b, 1'b0, 2, (i == 1) ? 100 : -1);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
